// File: rtl/icache_dm_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Address layout: | tag | index | word offset | byte (2) |.
package icache_dm_pkg;

  typedef enum logic {
    COMPARE = 1'b0,
    REFILL  = 1'b1
  } state_t;

  localparam int DEF_LINES = 8;
  localparam int DEF_WORDS = 4;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 32 - 2 - $clog2(lines) - $clog2(words);
  endfunction

  localparam int OFFSET_W = off_w(DEF_WORDS);
  localparam int INDEX_W  = idx_w(DEF_LINES);
  localparam int TAG_W    = tag_w(DEF_LINES, DEF_WORDS);

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the instruction cache.
// One synchronous write port, one asynchronous read port.
module icache_line_store #(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int TW    = 25,
  parameter int IW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_widx,
  input  logic [TW-1:0]         i_wtag,
  input  logic [32*WORDS-1:0]   i_wline,
  input  logic [IW-1:0]         i_ridx,
  output logic                  o_valid,
  output logic [TW-1:0]         o_tag,
  output logic [32*WORDS-1:0]   o_line
);

  logic [LINES-1:0]      r_valid;
  logic [TW-1:0]         r_tag  [LINES];
  logic [32*WORDS-1:0]   r_data [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data arrays are never reset; valid guards them.
  always_ff @(posedge clk) begin
    if (i_we && !rst) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wline;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_line  = r_data[i_ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a COMPARE/REFILL controller.
// Hits are served combinationally; a miss stalls until the line arrives.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  proc_read,
  input  logic [31:0]                           proc_addr,
  output logic [31:0]                           proc_rdata,
  output logic                                  proc_stall,
  output logic                                  mem_read,
  output logic [tag_w(LINES,WORDS)+idx_w(LINES)-1:0] mem_addr,
  input  logic [32*WORDS-1:0]                   mem_rdata,
  input  logic                                  mem_ready,
  output logic [15:0]                           miss_count
);

  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);

  state_t                r_state;
  logic [TW-1:0]         r_tag;
  logic [IW-1:0]         r_idx;
  logic [15:0]           r_miss;

  logic [OW-1:0]         w_off;
  logic [IW-1:0]         w_idx;
  logic [TW-1:0]         w_tag;
  logic                  w_valid;
  logic [TW-1:0]         w_stag;
  logic [32*WORDS-1:0]   w_line;
  logic                  w_hit;
  logic                  w_we;
  logic                  w_unused;

  assign w_off    = proc_addr[2 +: OW];
  assign w_idx    = proc_addr[2+OW +: IW];
  assign w_tag    = proc_addr[31 -: TW];
  assign w_unused = ^proc_addr[1:0];

  assign w_we = (r_state == REFILL) && mem_ready && !rst;

  icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TW    (TW),
    .IW    (IW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wtag  (r_tag),
    .i_wline (mem_rdata),
    .i_ridx  (w_idx),
    .o_valid (w_valid),
    .o_tag   (w_stag),
    .o_line  (w_line)
  );

  assign w_hit = (r_state == COMPARE) && proc_read &&
                 w_valid && (w_stag == w_tag);

  assign proc_rdata = w_hit ? w_line[32*w_off +: 32] : 32'd0;
  assign proc_stall = (r_state == REFILL) || (proc_read && !w_hit);
  assign mem_read   = (r_state == REFILL);
  assign mem_addr   = mem_read ? {r_tag, r_idx} : '0;
  assign miss_count = r_miss;

  // Controller: latch the missing line address, wait for memory, count misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COMPARE;
      r_miss  <= 16'd0;
    end else begin
      unique case (r_state)
        COMPARE: begin
          if (proc_read && !w_hit) begin
            r_state <= REFILL;
            r_tag   <= w_tag;
            r_idx   <= w_idx;
            if (r_miss != 16'hFFFF) r_miss <= r_miss + 16'd1;
          end
        end
        REFILL: begin
          if (mem_ready) r_state <= COMPARE;
        end
        default: r_state <= COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm with a latency-controlled memory model
// and a scoreboard of expected fetch results.
module tb_icache_dm;

  logic         clk;
  logic         rst;
  logic         proc_read;
  logic [31:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  miss_count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    logic [31:0] wa;
    wa = a >> 2;
    return wa * 32'h11111111;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++)
      l[32*k +: 32] = mw({la, 4'h0} + 32'(4*k));
    return l;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    proc_read = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one fetch; memory answers `lat` cycles after mem_read rises.
  task automatic fetch(input logic [31:0] a, input int lat,
                       input int exp_st, input string nm);
    int st;
    int rc;
    bit done;
    logic [31:0] got;
    logic [31:0] exp;
    proc_read = 1'b1;
    proc_addr = a;
    exp_q.push_back(mw(a));
    st = 0;
    rc = 0;
    done = 0;
    got = '0;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (!proc_stall) begin
        got = proc_rdata;
        done = 1;
      end else begin
        st++;
        if (mem_read) begin
          n_assert++;
          if (mem_addr !== a[31:4]) begin
            n_fail++;
            $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, a[31:4]);
          end
          if (rc == lat) begin
            mem_ready = 1'b1;
            mem_rdata = line_of(a[31:4]);
          end
          rc++;
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
      end
    end
    exp = exp_q.pop_front();
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: stall still high after %0d cycles", nm, st);
    end else if (got !== exp) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h", nm, got, exp);
    end
    n_assert++;
    if (st != exp_st) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, st, exp_st);
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
    proc_read = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    proc_addr = 32'h0;
    #1;
    n_assert++;
    if ({proc_stall, mem_read, mem_addr, proc_rdata, miss_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b mr=%b ma=%h rd=%h mc=%0d want all 0",
               proc_stall, mem_read, mem_addr, proc_rdata, miss_count);
    end
  endtask

  task automatic test_basic();
    fetch(32'h0, 3, 5, "basic_miss");
    fetch(32'h4, 3, 0, "basic_hit");
    #1;
    n_assert++;
    if (miss_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_miss_count: got %0d want 1", miss_count);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    fetch(32'h00, 1, 3, "conf_fill0");
    fetch(32'h80, 1, 3, "conf_fill80");
    fetch(32'h00, 1, 3, "conf_refill0");
    #1;
    n_assert++;
    if (miss_count !== 16'd3) begin
      n_fail++;
      $display("FAIL conf_miss_count: got %0d want 3", miss_count);
    end
  endtask

  task automatic test_reset_refill();
    do_reset();
    proc_read = 1'b1;
    proc_addr = 32'h40;
    #1;
    n_assert++;
    if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_miss_cycle: stall=%b mr=%b want 1 0", proc_stall, mem_read);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h4) begin
      n_fail++;
      $display("FAIL rr_refill: mr=%b ma=%h want 1 0000004", mem_read, mem_addr);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = ~line_of(28'h4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    proc_read = 1'b0;
    #1;
    n_assert++;
    if ({mem_read, proc_stall, miss_count} !== '0) begin
      n_fail++;
      $display("FAIL rr_after_reset: mr=%b stall=%b mc=%0d want 0 0 0",
               mem_read, proc_stall, miss_count);
    end
    fetch(32'h40, 0, 2, "rr_refetch");
  endtask

  task automatic test_sweep(input int exp_miss_st, input int exp_total,
                            input string nm);
    for (int a = 0; a < 32'h80; a += 4) begin
      fetch(32'(a), 0, ((a % 16) == 0) ? exp_miss_st : 0, nm);
    end
    #1;
    n_assert++;
    if (miss_count !== 16'(exp_total)) begin
      n_fail++;
      $display("FAIL %s miss_count: got %0d want %0d", nm, miss_count, exp_total);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      proc_read = 1'b0;
      proc_addr = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_assert++;
      if ({proc_stall, mem_read, mem_addr, proc_rdata} !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: stall=%b mr=%b ma=%h rd=%h want all 0",
                 i, proc_stall, mem_read, mem_addr, proc_rdata);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    n_assert++;
    if (miss_count !== 16'd8) begin
      n_fail++;
      $display("FAIL idle_miss_count: got %0d want 8", miss_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    proc_read = 1'b0;
    proc_addr = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_basic();
    test_conflict();
    test_reset_refill();
    do_reset();
    test_sweep(2, 8, "sweep1");
    test_idle();
    test_sweep(0, 8, "sweep2");
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 The block SHALL have parameter LINES, default 8, meaning number of direct-mapped cache lines (power of two).
REQ-002 The block SHALL have parameter WORDS, default 4, meaning 32-bit words per line (power of two).
REQ-003 The block SHALL have port clk  input  1  the single clock; every state element updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port proc_read  input  1  the core requests an instruction fetch this cycle.
REQ-006 The block SHALL have port proc_addr  input  32  byte address of the fetch (the core's IR_addr); bits [1:0] ignored.
REQ-007 The block SHALL have port proc_rdata  output  32  instruction word (the core's IR).
REQ-008 The block SHALL have port proc_stall  output  1  fetch not yet served; the core must hold its PC.
REQ-009 The block SHALL have port mem_read  output  1  line refill request to instruction memory.
REQ-010 The block SHALL have port mem_addr  output  28  line address, equal to proc_addr[31:4] for the default geometry.
REQ-011 The block SHALL have port mem_rdata  input  128  refill line; word k occupies bits [32k+31:32k].
REQ-012 The block SHALL have port mem_ready  input  1  mem_rdata is valid this cycle and the request is complete.
REQ-013 The block SHALL have port miss_count  output  16  number of refills started since reset, saturating.

Function
REQ-014 Address split SHALL be: word offset = addr[3:2], index = addr[6:4], tag = addr[31:7] (25 bits) for defaults, with widths derived from the parameters.
REQ-015 State machine SHALL have two states, COMPARE and REFILL.
REQ-016 In COMPARE, hit = proc_read & valid[index] & (tag_store[index] == tag).
REQ-017 On a hit, proc_rdata SHALL be the selected word in the same cycle (combinational), with proc_stall=0.
REQ-018 On a miss in COMPARE, proc_stall SHALL be 1 in the same cycle, miss_count SHALL increment, and the next state SHALL be REFILL.
REQ-019 With proc_read=0, proc_stall SHALL be 0, proc_rdata SHALL be 0, and the state SHALL remain COMPARE.
REQ-020 In REFILL, mem_read SHALL be 1 and mem_addr SHALL equal {tag,index}, held stable until mem_ready; proc_stall SHALL be 1.
REQ-021 On mem_ready in REFILL: store the line, write the tag, set valid[index], and return to COMPARE; the retried access then hits one cycle later.
REQ-022 Miss penalty SHALL be 1 (COMPARE) + N (memory cycles until mem_ready) + 1 (hit cycle) cycles.
REQ-023 mem_ready arriving in COMPARE SHALL be ignored.
REQ-024 The core SHALL hold proc_addr stable while proc_stall=1; the block latches the refill tag/index at the miss and does not re-sample proc_addr.
REQ-025 miss_count SHALL saturate at 16'hFFFF.
REQ-026 mem_read SHALL be 0 and mem_addr SHALL be 0 in COMPARE.

Reset
REQ-027 While rst=1 at a clock edge: state to COMPARE, all valid bits to 0, miss_count to 0; tag and data arrays are not reset.
REQ-028 Reset during REFILL SHALL abandon the refill: mem_read=0 in the next cycle and no line is written, even if mem_ready coincides with reset.
REQ-029 Immediately after reset, every access SHALL miss.

Structure
REQ-030 A shared package SHALL hold the state enum (COMPARE, REFILL) and the derived widths OFFSET_W, INDEX_W, and TAG_W.
REQ-031 One sub-module, icache_line_store, SHALL hold the tag, valid, and data arrays, with one write port and one asynchronous read port; the FSM lives in the top module.

Verification
REQ-032 Reset, then proc_read=1 and proc_addr=0x00000000, with memory returning 0x33333333_22222222_11111111_00000000 after 3 cycles -> mem_addr=0 and stall for 5 cycles; then proc_rdata=0x00000000; then proc_addr=0x4 hits with rdata=0x11111111 and no stall; miss_count=1.
REQ-033 A conflict test SHALL fill 0x00000000, then access 0x00000080 (same index, different tag) -> a second refill with mem_addr=0x0000008; then 0x00000000 misses again; miss_count=3.
REQ-034 A reset test SHALL assert rst while in REFILL in the same cycle as mem_ready -> the state is COMPARE and the next access to the same address misses again.
REQ-035 With proc_read=0 and mem_ready pulsed randomly for 20 cycles -> stall=0, mem_read=0, and no array writes.
REQ-036 Sweeping 0x0 to 0x7C sequentially with a 1-cycle memory -> exactly 8 misses, every returned word matching the memory model, and a second sweep with 0 misses.
